uart_tx_frame_arbiter: RTL

//  Shares one UART transmitter between two frame sources: req0 = periodic tank-state frame, req1 = event frame.

---
 rtl/uart_tx_frame_arbiter_if.sv | 46 ++++
 rtl/uart_tx_frame_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_frame_arbiter_if                                     |
// | Description : Byte-stream bundle between two frame packetizers, the frame  |
// |               arbiter and the UART TX core.                                |
// |   req0_valid/data/last  source 0 byte offer, ready = byte taken this cycle |
// |   req1_valid/data/last  source 1 byte offer, same handshake                |
// |   tx_start/tx_data      load-and-send pulse plus byte to the UART core     |
// |   tx_busy/tx_done       UART core shifting / stop bit finished pulse       |
// |   modport master        arbiter side                                       |
// |   modport slave         packetizer + UART core side                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface uart_tx_frame_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    output tx_start, tx_data,
    input  tx_busy, tx_done
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    input  tx_start, tx_data,
    output tx_busy, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_frame_arbiter                                        |
// | Description : Shares one UART transmitter between a periodic tank-state    |
// |               frame source (req0) and an event frame source (req1).        |
// |               Whole frames are granted round-robin, each prefixed with     |
// |               SYNC_LEN sync bytes, paced on tx_done and guarded by a       |
// |               tx_done watchdog. Optional trailing XOR checksum byte when   |
// |               FRAME_CHECKSUM_EN is defined.                                |
// | Ports       : clk          system clock                                    |
// |               rst          asynchronous, active-low reset                  |
// |               bus          uart_tx_frame_arbiter_if.master (sources + UART)|
// |               grant        one-hot frame owner, 2'b00 = none               |
// |               timeout_err  one-cycle pulse on tx_done watchdog expiry      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_frame_arbiter #(
  parameter int unsigned SYNC_LEN       = 3,
  parameter logic [7:0]  SYNC_BYTE      = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  uart_tx_frame_arbiter_if.master        bus,
  output logic [1:0]                     grant,
  output logic                           timeout_err
);

  localparam logic [3:0]  c_sync_len  = 4'(SYNC_LEN);
  localparam logic [14:0] c_wdog_last = 15'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] c_gap_last  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_WAIT  = 3'd2,
    S_DATA  = 3'd3,
    S_FLUSH = 3'd4,
    S_GAP   = 3'd5
`ifdef FRAME_CHECKSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_rr_ptr;      // 1: source 1 has priority on a tie
  logic [3:0]  r_sync_cnt;
  logic        r_last_sent;   // last byte of the frame has been handed over
  logic [14:0] r_wdog;
  logic [15:0] r_gap_cnt;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_req0_ready;
  logic        r_req1_ready;
  logic        r_timeout_err;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic        r_in_csum;     // the byte in flight is the checksum
`endif

  // Granted-source view of the request channel.
  logic       w_valid;
  logic [7:0] w_data;
  logic       w_last;
  logic       w_ready_now;

  assign w_valid     = r_grant[1] ? bus.req1_valid : bus.req0_valid;
  assign w_data      = r_grant[1] ? bus.req1_data  : bus.req0_data;
  assign w_last      = r_grant[1] ? bus.req1_last  : bus.req0_last;
  assign w_ready_now = r_req0_ready | r_req1_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_rr_ptr      <= 1'b0;
      r_sync_cnt    <= 4'd0;
      r_last_sent   <= 1'b0;
      r_wdog        <= 15'd0;
      r_gap_cnt     <= 16'd0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_csum        <= 8'h00;
      r_in_csum     <= 1'b0;
`endif
    end else begin
      r_tx_start    <= 1'b0;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            if (bus.req1_valid && (!bus.req0_valid || r_rr_ptr)) r_grant <= 2'b10;
            else                                                 r_grant <= 2'b01;
            r_sync_cnt  <= 4'd0;
            r_last_sent <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_csum      <= 8'h00;
            r_in_csum   <= 1'b0;
`endif
            r_state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= SYNC_BYTE;
            r_sync_cnt <= r_sync_cnt + 4'd1;
            r_wdog     <= 15'd0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // tx_done is checked first so it beats a same-cycle watchdog expiry.
          if (bus.tx_done) begin
            r_gap_cnt <= 16'd0;
            if (r_sync_cnt < c_sync_len) r_state <= S_SYNC;
            else if (!r_last_sent)       r_state <= S_DATA;
`ifdef FRAME_CHECKSUM_EN
            else if (!r_in_csum)         r_state <= S_CSUM;
`endif
            else                         r_state <= S_GAP;
          end else if (r_wdog == c_wdog_last) begin
            r_timeout_err <= 1'b1;
            r_gap_cnt     <= 16'd0;
            // Nothing left to drain once the last byte (or checksum) was taken.
            r_state       <= r_last_sent ? S_GAP : S_FLUSH;
          end else begin
            r_wdog <= r_wdog + 15'd1;
          end
        end
        S_DATA: begin
          if (w_valid && !bus.tx_busy) begin
            r_req0_ready <= ~r_grant[1];
            r_req1_ready <= r_grant[1];
            r_tx_start   <= 1'b1;
            r_tx_data    <= w_data;
            r_last_sent  <= w_last;
`ifdef FRAME_CHECKSUM_EN
            r_csum       <= r_csum ^ w_data;
`endif
            r_wdog       <= 15'd0;
            r_state      <= S_WAIT;
          end
        end
        S_FLUSH: begin
          // ready is registered, so skip the cycle in which the previous
          // pulse is still completing to avoid taking one byte twice.
          if (w_valid && !w_ready_now) begin
            r_req0_ready <= ~r_grant[1];
            r_req1_ready <= r_grant[1];
            if (w_last) begin
              r_gap_cnt <= 16'd0;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_rr_ptr <= ~r_grant[1];
            r_grant  <= 2'b00;
            r_state  <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        S_CSUM: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_csum;
            r_in_csum  <= 1'b1;
            r_wdog     <= 15'd0;
            r_state    <= S_WAIT;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.req0_ready = r_req0_ready;
  assign bus.req1_ready = r_req1_ready;
  assign grant          = r_grant;
  assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire
